imem_loader: RTL and testbench

Writer-side companion to the instruction memory, which the processor only reads. Accepts a byte stream on a valid/ready handshake, assembles 16-bit instruction words (high byte first) and writes them sequentially into instruction memory. Holds the processor off via cpu_hold while a load is in progress. Ends each frame with an XOR checksum check and reports done and error.

---
 rtl/imem_loader_pkg.sv | 32 +++
 rtl/imem_loader_if.sv | 30 +++
 rtl/imem_loader.sv | 152 +++++++++++++++
 tb/tb_imem_loader.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and helpers for the instruction-memory loader: FSM encoding,
// word/byte widths and the running checksum step.
package imem_loader_pkg;

  localparam int INSTR_W = 16;
  localparam int BYTE_W  = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    S_COUNT = 3'd1,
    S_HI    = 3'd2,
    S_LO    = 3'd3,
    S_CHK   = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  function automatic logic [BYTE_W-1:0] csum_step(input logic [BYTE_W-1:0] acc,
                                                  input logic [BYTE_W-1:0] b);
    return acc ^ b;
  endfunction

  // The loader takes stream bytes only in the four frame-parsing states.
  function automatic logic accepts_bytes(input state_e s);
    logic r;
    case (s)
      S_COUNT, S_HI, S_LO, S_CHK: r = 1'b1;
      default:                    r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input, instruction-memory write port and status lines of the loader.
// The slave modport is the loader itself; the master is whoever feeds the stream.
interface imem_loader_if #(
  parameter int ADDR_W = 8
);
  import imem_loader_pkg::*;

  logic                start;
  logic                in_valid;
  logic [BYTE_W-1:0]   in_data;
  logic                in_ready;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [INSTR_W-1:0]  wr_data;
  logic                cpu_hold;
  logic                busy;
  logic                done;
  logic                error;

  modport slave (
    input  start, in_valid, in_data,
    output in_ready, wr_en, wr_addr, wr_data, cpu_hold, busy, done, error
  );

  modport master (
    output start, in_valid, in_data,
    input  in_ready, wr_en, wr_addr, wr_data, cpu_hold, busy, done, error
  );

endinterface

// File: rtl/imem_loader.sv
// Loads COUNT / N x {HI,LO} / CHK byte frames into instruction memory, holding
// the CPU off for the duration and flagging an XOR checksum mismatch.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic         CLK,
  input  logic         reset,
  imem_loader_if.slave bus
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  state_e               state_r;
  state_e               state_nxt_s;
  logic [BYTE_W-1:0]    cnt_r;
  logic [BYTE_W-1:0]    idx_r;
  logic [BYTE_W-1:0]    csum_r;
  logic [BYTE_W-1:0]    hi_r;
  logic                 wr_en_r;
  logic [ADDR_W-1:0]    wr_addr_r;
  logic [INSTR_W-1:0]   wr_data_r;
  logic                 cpu_hold_r;
  logic                 done_r;
  logic                 error_r;
  logic                 in_ready_s;
  logic                 xfer_s;
  logic                 last_word_s;

  assign in_ready_s  = accepts_bytes(state_r);
  assign xfer_s      = bus.in_valid & in_ready_s;
  assign last_word_s = ((idx_r + 8'd1) == cnt_r);

  assign bus.in_ready = in_ready_s;
  assign bus.busy     = (state_r != IDLE);
  assign bus.wr_en    = wr_en_r;
  assign bus.wr_addr  = wr_addr_r;
  assign bus.wr_data  = wr_data_r;
  assign bus.cpu_hold = cpu_hold_r;
  assign bus.done     = done_r;
  assign bus.error    = error_r;

  // State register.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode; every byte-consuming state advances only on a transfer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) state_nxt_s = S_COUNT;
        else           state_nxt_s = IDLE;
      end
      S_COUNT: begin
        if (xfer_s) begin
          if (bus.in_data == 8'd0) state_nxt_s = S_CHK;
          else                     state_nxt_s = S_HI;
        end else begin
          state_nxt_s = S_COUNT;
        end
      end
      S_HI: begin
        if (xfer_s) state_nxt_s = S_LO;
        else        state_nxt_s = S_HI;
      end
      S_LO: begin
        if (xfer_s) begin
          if (last_word_s) state_nxt_s = S_CHK;
          else             state_nxt_s = S_HI;
        end else begin
          state_nxt_s = S_LO;
        end
      end
      S_CHK: begin
        if (xfer_s) state_nxt_s = S_DONE;
        else        state_nxt_s = S_CHK;
      end
      S_DONE:  state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Frame datapath: counters, checksum, word assembly and registered outputs.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      cnt_r      <= 8'd0;
      idx_r      <= 8'd0;
      csum_r     <= 8'd0;
      hi_r       <= 8'd0;
      wr_en_r    <= 1'b0;
      wr_addr_r  <= '0;
      wr_data_r  <= 16'd0;
      cpu_hold_r <= 1'b0;
      done_r     <= 1'b0;
      error_r    <= 1'b0;
    end else begin
      wr_en_r <= 1'b0;
      done_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            cpu_hold_r <= 1'b1;
            error_r    <= 1'b0;
            idx_r      <= 8'd0;
            csum_r     <= 8'd0;
          end
        end
        S_COUNT: begin
          if (xfer_s) begin
            cnt_r  <= bus.in_data;
            csum_r <= csum_step(csum_r, bus.in_data);
          end
        end
        S_HI: begin
          if (xfer_s) begin
            hi_r   <= bus.in_data;
            csum_r <= csum_step(csum_r, bus.in_data);
          end
        end
        S_LO: begin
          // Address is base plus word index, wrapping at the memory size.
          if (xfer_s) begin
            csum_r    <= csum_step(csum_r, bus.in_data);
            wr_data_r <= {hi_r, bus.in_data};
            wr_addr_r <= BASE + ADDR_W'(idx_r);
            wr_en_r   <= 1'b1;
            idx_r     <= idx_r + 8'd1;
          end
        end
        S_CHK: begin
          // done and the released hold become visible together in S_DONE.
          if (xfer_s) begin
            error_r    <= (bus.in_data != csum_r);
            done_r     <= 1'b1;
            cpu_hold_r <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed, table-driven bench for imem_loader: frame vectors with hand-computed
// writes and checksum results, plus a mid-frame reset sequence.
module tb_imem_loader;

  logic CLK;
  logic reset;
  logic start_d;
  logic in_valid_d;
  logic [7:0] in_data_d;
  logic sel_d;

  imem_loader_if #(.ADDR_W(8)) bus0 ();
  imem_loader_if #(.ADDR_W(8)) bus1 ();

  imem_loader #(.ADDR_W(8), .BASE_ADDR(0))   dut0 (.CLK(CLK), .reset(reset), .bus(bus0));
  imem_loader #(.ADDR_W(8), .BASE_ADDR(254)) dut1 (.CLK(CLK), .reset(reset), .bus(bus1));

  assign bus0.start    = start_d & ~sel_d;
  assign bus1.start    = start_d & sel_d;
  assign bus0.in_valid = in_valid_d & ~sel_d;
  assign bus1.in_valid = in_valid_d & sel_d;
  assign bus0.in_data  = in_data_d;
  assign bus1.in_data  = in_data_d;

  logic        m_in_ready, m_wr_en, m_cpu_hold, m_busy, m_done, m_error;
  logic [7:0]  m_wr_addr;
  logic [15:0] m_wr_data;
  assign m_in_ready = sel_d ? bus1.in_ready : bus0.in_ready;
  assign m_wr_en    = sel_d ? bus1.wr_en    : bus0.wr_en;
  assign m_wr_addr  = sel_d ? bus1.wr_addr  : bus0.wr_addr;
  assign m_wr_data  = sel_d ? bus1.wr_data  : bus0.wr_data;
  assign m_cpu_hold = sel_d ? bus1.cpu_hold : bus0.cpu_hold;
  assign m_busy     = sel_d ? bus1.busy     : bus0.busy;
  assign m_done     = sel_d ? bus1.done     : bus0.done;
  assign m_error    = sel_d ? bus1.error    : bus0.error;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [63:0] frame;
    logic [3:0]  nbytes;
    logic [1:0]  gap;
    logic        sel;
    logic [1:0]  nwr;
    logic [23:0] addrs;
    logic [47:0] words;
    logic        err;
  } vec_t;

  vec_t        vecs [6];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          done_cnt = 0;
  logic        last_err = 1'b0;
  logic [23:0] wq [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Write/done monitor on the falling edge, away from the active clock edge.
  always @(negedge CLK) begin
    if (!reset) begin
      if (m_wr_en) wq.push_back({m_wr_addr, m_wr_data});
      if (m_done) begin
        done_cnt++;
        last_err = m_error;
        check("hold_low_at_done", {31'd0, m_cpu_hold}, 32'd0);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    logic rdy;
    int   t;
    in_valid_d = 1'b1;
    in_data_d  = b;
    rdy = 1'b0;
    t   = 0;
    while (!rdy && t < 20) begin
      @(negedge CLK);
      rdy = m_in_ready;
      @(posedge CLK);
      #1;
      t++;
    end
    in_valid_d = 1'b0;
    if (!rdy) check("byte_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_frame(input vec_t v, input int id);
    int t;
    sel_d = v.sel;
    wq.delete();
    done_cnt = 0;
    start_d = 1'b1;
    @(posedge CLK);
    #1;
    start_d = 1'b0;
    @(negedge CLK);
    check("hold_after_start", {31'd0, m_cpu_hold}, 32'd1);
    check("busy_after_start", {31'd0, m_busy}, 32'd1);
    check("error_cleared_by_start", {31'd0, m_error}, 32'd0);
    @(posedge CLK);
    #1;
    for (int i = 0; i < int'(v.nbytes); i++) begin
      send_byte(v.frame[63-8*i -: 8]);
      if (v.gap != 2'd0 && i < int'(v.nbytes) - 1) begin
        repeat (int'(v.gap)) begin
          @(negedge CLK);
          check("ready_during_gap", {31'd0, m_in_ready}, 32'd1);
          @(posedge CLK);
          #1;
        end
      end
    end
    t = 0;
    while (done_cnt == 0 && t < 20) begin
      @(negedge CLK);
      t++;
    end
    if (done_cnt == 0) check("done_timeout", 32'd0, 32'd1);
    repeat (2) begin
      @(posedge CLK);
      #1;
    end
    check("done_pulse_count", done_cnt, 32'd1);
    check("error_flag", {31'd0, last_err}, {31'd0, v.err});
    check("error_sticky", {31'd0, m_error}, {31'd0, v.err});
    check("write_count", wq.size(), {30'd0, v.nwr});
    for (int k = 0; k < int'(v.nwr); k++) begin
      if (k < wq.size()) begin
        check("wr_addr", {24'd0, wq[k][23:16]}, {24'd0, v.addrs[23-8*k -: 8]});
        check("wr_data", {16'd0, wq[k][15:0]}, {16'd0, v.words[47-16*k -: 16]});
      end
    end
    if (v.nwr != 2'd0) begin
      check("wr_data_hold", {16'd0, m_wr_data}, {16'd0, v.words[47-16*(int'(v.nwr)-1) -: 16]});
    end
    check("busy_idle", {31'd0, m_busy}, 32'd0);
    check("hold_idle", {31'd0, m_cpu_hold}, 32'd0);
    if (n_fail != 0) $display("frame %0d: %0d failures so far", id, n_fail);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, {31'd0, m_in_ready}, 32'd0);
    check({tag, "_wr_en"},    {31'd0, m_wr_en},    32'd0);
    check({tag, "_wr_addr"},  {24'd0, m_wr_addr},  32'd0);
    check({tag, "_wr_data"},  {16'd0, m_wr_data},  32'd0);
    check({tag, "_cpu_hold"}, {31'd0, m_cpu_hold}, 32'd0);
    check({tag, "_busy"},     {31'd0, m_busy},     32'd0);
    check({tag, "_done"},     {31'd0, m_done},     32'd0);
    check({tag, "_error"},    {31'd0, m_error},    32'd0);
  endtask

  initial begin
    vecs[0] = '{frame:64'h02_10_44_10_81_C7_00_00, nbytes:4'd6, gap:2'd0, sel:1'b0,
                nwr:2'd2, addrs:24'h00_01_00, words:48'h1044_1081_0000, err:1'b0};
    vecs[1] = '{frame:64'h02_10_44_10_81_C7_00_00, nbytes:4'd6, gap:2'd3, sel:1'b0,
                nwr:2'd2, addrs:24'h00_01_00, words:48'h1044_1081_0000, err:1'b0};
    vecs[2] = '{frame:64'h01_12_34_00_00_00_00_00, nbytes:4'd4, gap:2'd0, sel:1'b0,
                nwr:2'd1, addrs:24'h00_00_00, words:48'h1234_0000_0000, err:1'b1};
    vecs[3] = '{frame:64'h00_00_00_00_00_00_00_00, nbytes:4'd2, gap:2'd0, sel:1'b0,
                nwr:2'd0, addrs:24'h00_00_00, words:48'h0000_0000_0000, err:1'b0};
    vecs[4] = '{frame:64'h00_01_00_00_00_00_00_00, nbytes:4'd2, gap:2'd1, sel:1'b0,
                nwr:2'd0, addrs:24'h00_00_00, words:48'h0000_0000_0000, err:1'b1};
    vecs[5] = '{frame:64'h03_AA_AA_BB_BB_CC_CC_03, nbytes:4'd8, gap:2'd0, sel:1'b1,
                nwr:2'd3, addrs:24'hFE_FF_00, words:48'hAAAA_BBBB_CCCC, err:1'b0};

    reset      = 1'b1;
    start_d    = 1'b0;
    in_valid_d = 1'b0;
    in_data_d  = 8'h00;
    sel_d      = 1'b0;
    #12;
    check_all_zero("reset");
    @(negedge CLK);
    reset = 1'b0;
    @(posedge CLK);
    #1;

    for (int v = 0; v < 6; v++) run_frame(vecs[v], v);

    // Reset after the HI byte of the first word; the pending LO byte stays offered.
    sel_d = 1'b0;
    wq.delete();
    start_d = 1'b1;
    @(posedge CLK);
    #1;
    start_d = 1'b0;
    send_byte(8'h02);
    send_byte(8'h10);
    in_valid_d = 1'b1;
    in_data_d  = 8'h44;
    reset = 1'b1;
    #2;
    check_all_zero("midreset");
    @(posedge CLK);
    #1;
    reset = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    in_valid_d = 1'b0;
    check("no_write_after_reset", wq.size(), 32'd0);
    check("idle_after_reset", {31'd0, m_busy}, 32'd0);
    run_frame(vecs[0], 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
